// File: rtl/hamming16t11d_scrubber_if.sv
// Memory-side bus of the Hamming(16,11) scrubber: one request channel
// shared by reads and write-backs, plus the read-data return path.
interface hamming16t11d_scrubber_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [15:0]       mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [15:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/hamming16t11d_scrubber.sv
// Background scrubber: sweeps DEPTH Hamming(16,11) SEC-DED words, writes back
// single-bit corrections and counts corrected / uncorrectable words.
module hamming16t11d_scrubber #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned PERIOD = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      start_i,
  input  logic                      clr_i,
  hamming16t11d_scrubber_if.master  mem,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               sec_cnt_o,
  output logic [15:0]               ded_cnt_o,
  output logic                      ded_o,
  output logic [ADDR_W-1:0]         ded_addr_o
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [PW-1:0]     period_cnt;
  logic [15:0]       word_q;
  logic [15:0]       wdata;
  logic              req;
  logic              we;
  logic              busy;
  logic              done;
  logic              ded;
  logic [ADDR_W-1:0] ded_addr;
  logic [15:0]       sec_cnt;
  logic [15:0]       ded_cnt;

  logic [3:0]        syndrome;
  logic              parity;
  logic [15:0]       corrected;
  logic              sec_hit;
  logic              ded_hit;

  // Syndrome is the XOR of the indices of all set bits; a lone flipped bit
  // therefore names its own position (0 when the overall parity bit flipped).
  always_comb begin
    syndrome = '0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (word_q[i]) syndrome = syndrome ^ 4'(i);
    end
    parity    = ^word_q;
    corrected = word_q ^ (16'(1) << syndrome);
  end

  assign sec_hit = (state == CHECK) && parity;
  assign ded_hit = (state == CHECK) && !parity && (syndrome != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr       <= '0;
      period_cnt <= '0;
      word_q     <= '0;
      wdata      <= '0;
      req        <= 1'b0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ded        <= 1'b0;
      ded_addr   <= '0;
    end else begin
      done <= 1'b0;
      ded  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i || (en_i && period_cnt == PW'(PERIOD - 1))) begin
            period_cnt <= '0;
            addr       <= '0;
            req        <= 1'b1;
            we         <= 1'b0;
            busy       <= 1'b1;
            state      <= RD_REQ;
          end else if (en_i) begin
            period_cnt <= period_cnt + PW'(1);
          end else begin
            period_cnt <= '0;
          end
        end
        RD_REQ: begin
          if (mem.mem_gnt_i) begin
            req   <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem.mem_rvalid_i) begin
            word_q <= mem.mem_rdata_i;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (parity) begin
            wdata <= corrected;
            req   <= 1'b1;
            we    <= 1'b1;
            state <= WR_REQ;
          end else begin
            if (syndrome != '0) begin
              ded      <= 1'b1;
              ded_addr <= addr;
            end
            state <= NEXT;
          end
        end
        WR_REQ: begin
          if (mem.mem_gnt_i) begin
            req   <= 1'b0;
            we    <= 1'b0;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (addr == ADDR_W'(DEPTH - 1)) begin
            addr  <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            req   <= 1'b1;
            we    <= 1'b0;
            state <= RD_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating event counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (sec_hit && sec_cnt != '1) sec_cnt <= sec_cnt + 16'd1;
      if (ded_hit && ded_cnt != '1) ded_cnt <= ded_cnt + 16'd1;
    end
  end

  assign mem.mem_req_o   = req;
  assign mem.mem_we_o    = we;
  assign mem.mem_addr_o  = addr;
  assign mem.mem_wdata_o = wdata;
  assign busy_o          = busy;
  assign done_o          = done;
  assign ded_o           = ded;
  assign ded_addr_o      = ded_addr;
  assign sec_cnt_o       = sec_cnt;
  assign ded_cnt_o       = ded_cnt;

endmodule

// File: tb/tb_hamming16t11d_scrubber.sv
// Self-checking bench for hamming16t11d_scrubber: behavioural memory with
// programmable grant/rvalid delays and an injected-flip reference model.
module tb_hamming16t11d_scrubber;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned PERIOD = 8;

  logic            tb_clk_i = 1'b0;
  logic            rst_i    = 1'b1;
  logic            en_i     = 1'b0;
  logic            start_i  = 1'b0;
  logic            clr_i    = 1'b0;
  logic            busy_o, done_o, ded_o;
  logic [15:0]     sec_cnt_o, ded_cnt_o;
  logic [AW-1:0]   ded_addr_o;

  hamming16t11d_scrubber_if #(.ADDR_W(AW)) bus ();

  hamming16t11d_scrubber #(.DEPTH(DEPTH), .ADDR_W(AW), .PERIOD(PERIOD)) dut (
    .clk_i      (tb_clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .start_i    (start_i),
    .clr_i      (clr_i),
    .mem        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sec_cnt_o  (sec_cnt_o),
    .ded_cnt_o  (ded_cnt_o),
    .ded_o      (ded_o),
    .ded_addr_o (ded_addr_o)
  );

  always #5 tb_clk_i = ~tb_clk_i;

  int checks = 0;
  int passes = 0;

  logic [15:0] mem_model [DEPTH];
  logic [15:0] orig      [DEPTH];
  logic [15:0] loaded    [DEPTH];
  int          nflip     [DEPTH];

  int          gnt_dly = 0, rv_dly = 0;
  int          wait_cnt = 0, rv_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  int          rv_events = 0;
  logic [AW-1:0] last_rv_addr = '0;
  bit          hold_v = 1'b0;
  logic [21:0] held = '0;
  int          done_pulses = 0, ded_pulses = 0, busy_cycles = 0;
  int          idle_run = 0, last_gap = 0;
  bit          prev_busy = 1'b0;
  logic [AW-1:0] rd_q[$], wr_addr_q[$];
  logic [15:0]   wr_data_q[$];

  int            exp_sec = 0, exp_ded = 0, exp_ded_pulses = 0;
  logic [AW-1:0] exp_ded_addr = '0;
  logic [AW-1:0] exp_wa[$];
  logic [15:0]   exp_wd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Codeword built from its definition: data in non-power-of-two slots,
  // parity bit 2^k covers every index with bit k set, bit 0 is overall parity.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int unsigned k;
    logic p;
    w = '0;
    k = 0;
    for (int unsigned pos = 3; pos < 16; pos++) begin
      if (pos != 4 && pos != 8) begin
        w[pos] = d[k];
        k++;
      end
    end
    for (int unsigned pb = 0; pb < 4; pb++) begin
      p = 1'b0;
      for (int unsigned pos = 1; pos < 16; pos++)
        if (((pos >> pb) & 1) == 1) p = p ^ w[pos];
      w[1 << pb] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  // Memory monitor: everything sampled at the rising edge is the pre-edge value.
  initial begin
    forever begin
      @(posedge tb_clk_i);
      if (rst_i) begin
        rd_pend = 1'b0; wait_cnt = 0; hold_v = 1'b0; idle_run = 0; prev_busy = 1'b0;
      end else begin
        if (bus.mem_rvalid_i) begin
          rd_pend = 1'b0; rv_events++; last_rv_addr = rd_addr;
        end else if (rd_pend) begin
          rv_cnt++;
        end
        if (hold_v)
          check("req_stable", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, held);
        if (bus.mem_req_o && bus.mem_gnt_i) begin
          hold_v = 1'b0; wait_cnt = 0;
          if (bus.mem_we_o) begin
            mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
            wr_addr_q.push_back(bus.mem_addr_o);
            wr_data_q.push_back(bus.mem_wdata_o);
          end else begin
            rd_pend = 1'b1; rv_cnt = 0; rd_addr = bus.mem_addr_o;
            rd_q.push_back(bus.mem_addr_o);
          end
        end else if (bus.mem_req_o) begin
          hold_v = 1'b1; wait_cnt++;
          held = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
        end else begin
          hold_v = 1'b0; wait_cnt = 0;
        end
        if (done_o) done_pulses++;
        if (ded_o) ded_pulses++;
        if (busy_o) begin
          if (!prev_busy) last_gap = idle_run;
          idle_run = 0;
          busy_cycles++;
        end else begin
          idle_run++;
        end
        prev_busy = busy_o;
      end
    end
  end

  // Memory responder: drives grant/rvalid on the falling edge.
  initial begin
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    forever begin
      @(negedge tb_clk_i);
      bus.mem_gnt_i = bus.mem_req_o && (wait_cnt >= gnt_dly);
      if (rd_pend && rv_cnt >= rv_dly) begin
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = mem_model[rd_addr];
      end else begin
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 16'($urandom);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge tb_clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(2); rst_i = 1'b0;
    exp_sec = 0; exp_ded = 0; exp_ded_addr = '0;
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_pulses = 0; ded_pulses = 0; busy_cycles = 0;
  endtask

  task automatic load_clean();
    for (int i = 0; i < DEPTH; i++) begin
      orig[i] = encode(11'($urandom));
      mem_model[i] = orig[i];
      nflip[i] = 0;
    end
  endtask

  task automatic flip(input int a, input int b1, input int b2);
    mem_model[a][b1] = ~mem_model[a][b1];
    nflip[a] = 1;
    if (b2 >= 0) begin
      mem_model[a][b2] = ~mem_model[a][b2];
      nflip[a] = 2;
    end
  endtask

  task automatic flip_rand(input int a, input int n);
    int b1;
    b1 = int'($urandom_range(0, 15));
    if (n == 1) flip(a, b1, -1);
    else flip(a, b1, (b1 + int'($urandom_range(1, 15))) % 16);
  endtask

  // Expected outcome of one sweep, from the number of flips injected per word.
  task automatic model(input int clr_at);
    exp_wa.delete(); exp_wd.delete(); exp_ded_pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      loaded[i] = mem_model[i];
      if (nflip[i] == 1) begin
        exp_sec = (exp_sec < 65535) ? exp_sec + 1 : 65535;
        exp_wa.push_back(AW'(i)); exp_wd.push_back(orig[i]);
      end else if (nflip[i] == 2) begin
        exp_ded = (exp_ded < 65535) ? exp_ded + 1 : 65535;
        exp_ded_addr = AW'(i); exp_ded_pulses++;
      end
      if (i == clr_at) begin exp_sec = 0; exp_ded = 0; end
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(1); start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, n;
    base = done_pulses; n = 0;
    while (done_pulses == base && n < budget) begin tick(1); n++; end
    check({tag, "_done_seen"}, 32'(done_pulses != base), 1);
  endtask

  task automatic check_sweep(input string tag, input bit timing);
    check({tag, "_rd_count"}, rd_q.size(), DEPTH);
    for (int i = 0; i < rd_q.size() && i < DEPTH; i++) check({tag, "_rd_addr"}, rd_q[i], i);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_wa.size());
    for (int i = 0; i < wr_addr_q.size() && i < exp_wa.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr_q[i], exp_wa[i]);
      check({tag, "_wr_data"}, wr_data_q[i], exp_wd[i]);
    end
    check({tag, "_sec_cnt"}, sec_cnt_o, exp_sec);
    check({tag, "_ded_cnt"}, ded_cnt_o, exp_ded);
    check({tag, "_ded_addr"}, ded_addr_o, exp_ded_addr);
    check({tag, "_ded_pulses"}, ded_pulses, exp_ded_pulses);
    check({tag, "_done_pulses"}, done_pulses, 1);
    check({tag, "_busy_end"}, busy_o, 0);
    for (int i = 0; i < DEPTH; i++)
      check({tag, "_mem"}, mem_model[i], (nflip[i] == 2) ? loaded[i] : orig[i]);
    if (timing) check({tag, "_busy_cycles"}, busy_cycles, DEPTH * 4 + exp_wa.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, base;
    tick(3);
    rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ded", ded_o, 0);
    check("rst_req", bus.mem_req_o, 0);
    check("rst_we", bus.mem_we_o, 0);
    check("rst_wdata", bus.mem_wdata_o, 0);
    check("rst_sec", sec_cnt_o, 0);
    check("rst_dedcnt", ded_cnt_o, 0);
    check("rst_dedaddr", ded_addr_o, 0);
    tick(12);
    check("idle_no_auto", busy_o, 0);

    // Clean sweep; a second start mid-sweep must be dropped, not queued.
    load_clean(); model(-1); clear_logs();
    pulse_start(); tick(20); pulse_start();
    wait_done("clean", 2000); tick(20);
    check_sweep("clean", 1'b1);

    load_clean(); flip(5, 9, -1); model(-1); clear_logs();
    pulse_start(); wait_done("sec", 2000); tick(3);
    check_sweep("sec", 1'b1);

    load_clean(); flip(7, 3, 4); model(-1); clear_logs();
    pulse_start(); wait_done("ded", 2000); tick(3);
    check_sweep("ded", 1'b1);

    gnt_dly = 3; rv_dly = 2;
    load_clean();
    for (int i = 0; i < DEPTH; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 1) flip_rand(i, 1);
      else if (r == 2) flip_rand(i, 2);
    end
    model(-1); clear_logs();
    pulse_start(); wait_done("slow", 4000); tick(3);
    check_sweep("slow", 1'b0);

    // Clear lands on the CHECK cycle of word 9, which is a single error.
    load_clean(); flip_rand(2, 1); flip_rand(9, 1); flip_rand(12, 2);
    model(9); clear_logs();
    base = rv_events;
    pulse_start();
    n = 0;
    while (!(rv_events != base && last_rv_addr == AW'(9)) && n < 3000) begin tick(1); n++; end
    check("clr_sync", 32'(last_rv_addr == AW'(9)), 1);
    check("clr_pre_sec", sec_cnt_o, exp_sec == 0 ? 32'(sec_cnt_o != 0 ? sec_cnt_o : 1) : 0);
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    check("clr_wins", sec_cnt_o, 0);
    wait_done("clr", 4000); tick(3);
    check_sweep("clr", 1'b0);
    gnt_dly = 0; rv_dly = 0;

    // Automatic sweeps every PERIOD idle cycles.
    do_reset();
    check("rst2_dedaddr", ded_addr_o, 0);
    check("rst2_dedcnt", ded_cnt_o, 0);
    load_clean(); model(-1); clear_logs();
    en_i = 1'b1;
    wait_done("auto1", 400);
    wait_done("auto2", 400);
    check("auto_gap", last_gap, PERIOD);
    check("auto_rd_count", rd_q.size(), 2 * DEPTH);
    clear_logs();
    n = 0;
    while (!busy_o && n < 100) begin tick(1); n++; end
    check("auto3_start", busy_o, 1);
    check("auto3_gap", last_gap, PERIOD);
    tick(10); en_i = 1'b0;
    wait_done("auto3", 400); tick(40);
    check("en_drop_rd_count", rd_q.size(), DEPTH);
    check("en_drop_done", done_pulses, 1);
    check("en_drop_idle", busy_o, 0);

    // Reset while a write-back is waiting for its grant.
    load_clean(); flip(3, 6, -1); clear_logs();
    gnt_dly = 6;
    pulse_start();
    n = 0;
    while (!(bus.mem_req_o && bus.mem_we_o) && n < 500) begin tick(1); n++; end
    check("wr_req_seen", 32'(bus.mem_req_o && bus.mem_we_o), 1);
    rst_i = 1'b1; tick(1); rst_i = 1'b0;
    exp_sec = 0; exp_ded = 0; exp_ded_addr = '0;
    check("wrrst_req", bus.mem_req_o, 0);
    check("wrrst_we", bus.mem_we_o, 0);
    check("wrrst_wdata", bus.mem_wdata_o, 0);
    check("wrrst_busy", busy_o, 0);
    check("wrrst_done", done_o, 0);
    check("wrrst_ded", ded_o, 0);
    check("wrrst_sec", sec_cnt_o, 0);
    tick(5);
    check("wrrst_no_write", wr_addr_q.size(), 0);
    check("wrrst_mem3", mem_model[3] ^ orig[3], 16'h0040);
    gnt_dly = 0;
    model(-1); clear_logs();
    pulse_start(); wait_done("post_rst", 2000); tick(3);
    check_sweep("post_rst", 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
